key_inventory: RTL and testbench

Holds the player's three key counts and money, and serves as the direct upstream source of the key-table drawer's `ValueArr`. Game logic issues single-word inventory requests through a valid/ready handshake. Each request executes in a 3-state FSM and returns a one-cycle response with a success flag. Display-facing values are republished only on a frame-sync pulse, so the key table never shows a half-updated value mid-frame.

---
 rtl/key_inventory.sv | 178 +++++++++++++++++
 tb/tb_key_inventory.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_inventory.sv
// key_inventory: player key counts and money, with frame-synchronous display values.
//
// Game logic sends single-word requests over a valid/ready handshake. Each request
// passes IDLE -> EXEC -> RESP and returns a one-cycle response carrying a success
// flag. ValueArr feeds the key-table drawer.
//
// Build option: define INVENTORY_SHADOW_EN to add shadow registers. ValueArr then
// updates only on frame_sync. Without it, ValueArr follows the live registers.
//
// Ports:
//   CLK        - clock, rising edge
//   Reset      - synchronous active-high reset
//   req_valid  - request present
//   req_ready  - request accepted this cycle (high only in IDLE)
//   req_op     - opcode: 0 NOP, 1 ADD_KEY, 2 USE_KEY, 3 ADD_MONEY, 4 SPEND_MONEY, 5 CLEAR
//   req_arg    - key index in [1:0] or money amount in [8:0]
//   resp_valid - one-cycle completion pulse
//   resp_ok    - success flag, qualified by resp_valid
//   frame_sync - one-cycle pulse at vertical blank start
//   ValueArr   - [0..2] key counts, [3] money
module key_inventory #(
   parameter logic [8:0] KEY_MAX   = 9'd99,
   parameter logic [8:0] MONEY_MAX = 9'd511
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [8:0]      req_arg,
   output logic            resp_valid,
   output logic            resp_ok,
   input  logic            frame_sync,
   output logic [3:0][8:0] ValueArr
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [8:0]      arg_q, arg_d;
   logic [2:0][8:0] key_q, key_d;
   logic [8:0]      money_q, money_d;
   logic            req_ready_q, req_ready_d;
   logic            resp_valid_q, resp_valid_d;
   logic            resp_ok_q, resp_ok_d;

   logic [1:0]      idx;
   logic [8:0]      key_sel;
   logic [9:0]      sum10;

   assign idx   = arg_q[1:0];
   // 10-bit sum so the saturation compare sees any carry out of bit 8
   assign sum10 = {1'b0, money_q} + {1'b0, arg_q};

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      arg_d     = arg_q;
      key_d     = key_q;
      money_d   = money_q;
      resp_ok_d = resp_ok_q;

      key_sel = 9'd0;
      for (int i = 0; i < 3; i++) begin
         if (idx == 2'(i)) key_sel = key_q[i];
      end

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d    = req_op;
               arg_d   = req_arg;
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StResp;
            case (op_q)
               3'd0: resp_ok_d = 1'b1;
               3'd1: begin
                  if (idx == 2'd3 || key_sel == KEY_MAX) begin
                     resp_ok_d = 1'b0;
                  end else begin
                     for (int i = 0; i < 3; i++) begin
                        if (idx == 2'(i)) key_d[i] = key_q[i] + 9'd1;
                     end
                     resp_ok_d = 1'b1;
                  end
               end
               3'd2: begin
                  if (idx == 2'd3 || key_sel == 9'd0) begin
                     resp_ok_d = 1'b0;
                  end else begin
                     for (int i = 0; i < 3; i++) begin
                        if (idx == 2'(i)) key_d[i] = key_q[i] - 9'd1;
                     end
                     resp_ok_d = 1'b1;
                  end
               end
               3'd3: begin
                  money_d   = (sum10 > {1'b0, MONEY_MAX}) ? MONEY_MAX : sum10[8:0];
                  resp_ok_d = 1'b1;
               end
               3'd4: begin
                  if ({1'b0, money_q} >= {1'b0, arg_q}) begin
                     money_d   = money_q - arg_q;
                     resp_ok_d = 1'b1;
                  end else begin
                     resp_ok_d = 1'b0;
                  end
               end
               3'd5: begin
                  key_d     = '0;
                  money_d   = 9'd0;
                  resp_ok_d = 1'b1;
               end
               default: resp_ok_d = 1'b0;
            endcase
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Outputs are registered from the next state
      req_ready_d  = (state_d == StIdle);
      resp_valid_d = (state_d == StResp);
   end

`ifdef INVENTORY_SHADOW_EN
   logic [3:0][8:0] shadow_q, shadow_d;

   // Sampling the pre-edge live values means an EXEC-edge frame_sync sees pre-commit data
   always_comb begin
      shadow_d = shadow_q;
      if (frame_sync) shadow_d = {money_q, key_q};
   end

   assign ValueArr = shadow_q;
`else
   logic unused_frame_sync;
   assign unused_frame_sync = frame_sync;
   assign ValueArr          = {money_q, key_q};
`endif

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= StIdle;
         op_q         <= 3'd0;
         arg_q        <= 9'd0;
         key_q        <= '0;
         money_q      <= 9'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_ok_q    <= 1'b0;
`ifdef INVENTORY_SHADOW_EN
         shadow_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         arg_q        <= arg_d;
         key_q        <= key_d;
         money_q      <= money_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_ok_q    <= resp_ok_d;
`ifdef INVENTORY_SHADOW_EN
         shadow_q     <= shadow_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_ok    = resp_ok_q;

endmodule

// File: tb/tb_key_inventory.sv
// Directed testbench for key_inventory. Inputs are driven and outputs sampled on
// the falling clock edge. Expectations track both shadow and direct builds.
module tb_key_inventory;

   logic            CLK = 1'b0;
   logic            Reset = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [2:0]      req_op = 3'd0;
   logic [8:0]      req_arg = 9'd0;
   logic            resp_valid;
   logic            resp_ok;
   logic            frame_sync = 1'b0;
   logic [3:0][8:0] ValueArr;

   int compared   = 0;
   int mismatched = 0;

   key_inventory dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_arg    (req_arg),
      .resp_valid (resp_valid),
      .resp_ok    (resp_ok),
      .frame_sync (frame_sync),
      .ValueArr   (ValueArr)
   );

   always #5 CLK = ~CLK;

   // Issue one request. Returns at the falling edge where resp_valid is seen.
   task automatic issue(input logic [2:0] op, input logic [8:0] arg,
                        output logic ok, output int lat);
      int n;
      n = 0;
      @(negedge CLK);
      while (req_ready !== 1'b1 && n < 8) begin @(negedge CLK); n++; end
      req_valid = 1'b1; req_op = op; req_arg = arg;
      @(negedge CLK);
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 8) begin @(negedge CLK); n++; end
      compared++;
      if (n >= 8) begin
         mismatched++;
         $display("FAIL issue_timeout op=%0d: no resp_valid within 8 cycles", op);
      end
      ok  = resp_ok;
      lat = n;
   endtask

   task automatic pulse_frame();
      @(negedge CLK); frame_sync = 1'b1;
      @(negedge CLK); frame_sync = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(negedge CLK);
      compared += 4;
      if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", req_ready); end
      if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rv got %b want 0", resp_valid); end
      if (resp_ok !== 1'b0) begin mismatched++; $display("FAIL reset_ok got %b want 0", resp_ok); end
      if (ValueArr !== 36'd0) begin mismatched++; $display("FAIL reset_value got %h want 0", ValueArr); end
      Reset = 1'b0;
   endtask

   task automatic test_add_key();
      logic ok; int lat;
      logic [35:0] exp;
      for (int i = 0; i < 3; i++) begin
         issue(3'd1, 9'd1, ok, lat);
         compared++;
         if (ok !== 1'b1) begin mismatched++; $display("FAIL add_key_ok[%0d] got %b want 1", i, ok); end
         if (i == 0) begin
            compared++;
            if (lat !== 1) begin mismatched++; $display("FAIL latency got %0d want 1", lat); end
         end
      end
`ifdef INVENTORY_SHADOW_EN
      exp = 36'd0;
`else
      exp = {9'd0, 9'd0, 9'd3, 9'd0};
`endif
      compared++;
      if (ValueArr !== exp) begin mismatched++; $display("FAIL pre_frame got %h want %h", ValueArr, exp); end
      pulse_frame();
      compared++;
      if (ValueArr !== {9'd0, 9'd0, 9'd3, 9'd0}) begin
         mismatched++; $display("FAIL add_key_frame got %h want %h", ValueArr, {9'd0, 9'd0, 9'd3, 9'd0});
      end
   endtask

   task automatic test_illegal();
      logic ok; int lat;
      logic [2:0] ops [5] = '{3'd2, 3'd1, 3'd7, 3'd6, 3'd0};
      logic [8:0] args[5] = '{9'd0, 9'd3, 9'd1, 9'd1, 9'd0};
      logic       oks [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], args[i], ok, lat);
         compared++;
         if (ok !== oks[i]) begin
            mismatched++; $display("FAIL illegal_ok op=%0d got %b want %b", ops[i], ok, oks[i]);
         end
      end
      pulse_frame();
      compared++;
      if (ValueArr !== {9'd0, 9'd0, 9'd3, 9'd0}) begin
         mismatched++; $display("FAIL illegal_nochange got %h want %h", ValueArr, {9'd0, 9'd0, 9'd3, 9'd0});
      end
   endtask

   task automatic test_money();
      logic ok; int lat;
      // op, arg, expected ok, expected money after
      logic [2:0] ops  [10] = '{3'd5, 3'd3, 3'd3, 3'd5, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
      logic [8:0] args [10] = '{9'd0, 9'd500, 9'd20, 9'd0, 9'd510, 9'd511, 9'd410, 9'd100,
                                9'd0, 9'd1};
      logic       oks  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [8:0] mon  [10] = '{9'd0, 9'd500, 9'd511, 9'd0, 9'd510, 9'd510, 9'd100, 9'd0,
                                9'd0, 9'd0};
      for (int i = 0; i < 10; i++) begin
         issue(ops[i], args[i], ok, lat);
         pulse_frame();
         compared += 2;
         if (ok !== oks[i]) begin
            mismatched++; $display("FAIL money_ok[%0d] got %b want %b", i, ok, oks[i]);
         end
         if (ValueArr[3] !== mon[i]) begin
            mismatched++; $display("FAIL money_val[%0d] got %0d want %0d", i, ValueArr[3], mon[i]);
         end
      end
   endtask

   task automatic test_key_max();
      logic ok; int lat;
      issue(3'd5, 9'd0, ok, lat);
      for (int i = 0; i < 99; i++) issue(3'd1, 9'd0, ok, lat);
      issue(3'd1, 9'd0, ok, lat);
      pulse_frame();
      compared += 2;
      if (ok !== 1'b0) begin mismatched++; $display("FAIL key_max_ok got %b want 0", ok); end
      if (ValueArr[0] !== 9'd99) begin mismatched++; $display("FAIL key_max_val got %0d want 99", ValueArr[0]); end
      issue(3'd2, 9'd0, ok, lat);
      pulse_frame();
      compared += 2;
      if (ok !== 1'b1) begin mismatched++; $display("FAIL use_key_ok got %b want 1", ok); end
      if (ValueArr[0] !== 9'd98) begin mismatched++; $display("FAIL use_key_val got %0d want 98", ValueArr[0]); end
   endtask

   task automatic test_frame_exec();
      logic ok; int lat;
      logic [8:0] exp;
      issue(3'd5, 9'd0, ok, lat);
      for (int i = 0; i < 4; i++) issue(3'd1, 9'd2, ok, lat);
      pulse_frame();
      compared++;
      if (ValueArr[2] !== 9'd4) begin mismatched++; $display("FAIL fe_setup got %0d want 4", ValueArr[2]); end
      @(negedge CLK);
      req_valid = 1'b1; req_op = 3'd1; req_arg = 9'd2;
      @(negedge CLK);                 // now in EXEC; next edge commits
      req_valid = 1'b0; frame_sync = 1'b1;
      @(negedge CLK);
      frame_sync = 1'b0;
`ifdef INVENTORY_SHADOW_EN
      exp = 9'd4;
`else
      exp = 9'd5;
`endif
      compared += 3;
      if (resp_valid !== 1'b1) begin mismatched++; $display("FAIL fe_rv got %b want 1", resp_valid); end
      if (resp_ok !== 1'b1) begin mismatched++; $display("FAIL fe_ok got %b want 1", resp_ok); end
      if (ValueArr[2] !== exp) begin mismatched++; $display("FAIL fe_precommit got %0d want %0d", ValueArr[2], exp); end
      pulse_frame();
      compared++;
      if (ValueArr[2] !== 9'd5) begin mismatched++; $display("FAIL fe_next got %0d want 5", ValueArr[2]); end
   endtask

   task automatic test_back_to_back();
      int rdy_cnt, rv_cnt, first_rv;
      rdy_cnt = 0; rv_cnt = 0; first_rv = -1;
      @(negedge CLK);
      req_valid = 1'b1; req_op = 3'd0; req_arg = 9'd0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         if (req_ready === 1'b1) rdy_cnt++;
         if (resp_valid === 1'b1) begin rv_cnt++; if (first_rv < 0) first_rv = i; end
      end
      req_valid = 1'b0;
      compared += 3;
      if (rdy_cnt !== 4) begin mismatched++; $display("FAIL b2b_ready got %0d want 4", rdy_cnt); end
      if (rv_cnt !== 4) begin mismatched++; $display("FAIL b2b_resp got %0d want 4", rv_cnt); end
      if (first_rv !== 2) begin mismatched++; $display("FAIL b2b_first_resp got %0d want 2", first_rv); end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      int rv_seen;
      rv_seen = 0;
      @(negedge CLK);
      req_valid = 1'b1; req_op = 3'd3; req_arg = 9'd50;
      @(negedge CLK);                 // EXEC
      req_valid = 1'b0; Reset = 1'b1; frame_sync = 1'b1;
      @(negedge CLK);
      Reset = 1'b0; frame_sync = 1'b0;
      compared += 3;
      if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_rv got %b want 0", resp_valid); end
      if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
      if (ValueArr !== 36'd0) begin mismatched++; $display("FAIL rst_mid_value got %h want 0", ValueArr); end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (resp_valid === 1'b1) rv_seen++;
      end
      pulse_frame();
      compared += 2;
      if (rv_seen !== 0) begin mismatched++; $display("FAIL rst_mid_no_resp got %0d want 0", rv_seen); end
      if (ValueArr !== 36'd0) begin mismatched++; $display("FAIL rst_mid_live got %h want 0", ValueArr); end
   endtask

   initial begin
      test_reset();
      test_add_key();
      test_illegal();
      test_money();
      test_key_max();
      test_frame_exec();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
